// File: rtl/ysyx_20020207_lsu_if.sv
// LSU connection bundle: ALU-side issue fields, memory bus request/response and
// writeback result. master = ALU/bus environment, slave = the LSU.
interface ysyx_20020207_lsu_if;
  logic        alu_valid;
  logic [31:0] alu_result;
  logic        mem_ren;
  logic        mem_wen;
  logic [1:0]  mem_len;
  logic        mem_sign;
  logic [31:0] mem_wdata;

  logic        req_valid;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;

  logic        lsu_valid;
  logic [31:0] lsu_result;
  logic        lsu_busy;
  logic        lsu_err;

  modport master (
    output alu_valid, alu_result, mem_ren, mem_wen, mem_len, mem_sign, mem_wdata,
    output req_ready, resp_valid, resp_rdata,
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask,
    input  lsu_valid, lsu_result, lsu_busy, lsu_err
  );

  modport slave (
    input  alu_valid, alu_result, mem_ren, mem_wen, mem_len, mem_sign, mem_wdata,
    input  req_ready, resp_valid, resp_rdata,
    output req_valid, req_wen, req_addr, req_wdata, req_wmask,
    output lsu_valid, lsu_result, lsu_busy, lsu_err
  );
endinterface

// File: rtl/ysyx_20020207_lsu.sv
// Single-outstanding load/store unit: IDLE -> REQ -> WAIT -> DONE, lane-aligned stores, extended loads.
// Optional macro LSU_MISALIGN_CHECK_EN: misaligned half/word accesses skip the bus and flag lsu_err.
module ysyx_20020207_lsu (
  input  logic                  clock,
  input  logic                  reset,
  ysyx_20020207_lsu_if.slave    bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned MASKW = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [1:0]       len_q;
  logic             sign_q;

  logic             accept_c;
  logic             is_mem_c;
  logic             misalign_c;
  logic [1:0]       lane_c;
  logic [XLEN-1:0]  st_wdata_c;
  logic [MASKW-1:0] st_wmask_c;
  logic [XLEN-1:0]  byte_sh_c;
  logic [XLEN-1:0]  half_sh_c;
  logic [XLEN-1:0]  load_c;

  assign accept_c = (state == IDLE) && bus.alu_valid;
  assign is_mem_c = bus.mem_ren | bus.mem_wen;
  assign lane_c   = bus.alu_result[1:0];

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign_c = is_mem_c &&
                      (((bus.mem_len == 2'b01) && bus.alu_result[0]) ||
                       (bus.mem_len[1] && (bus.alu_result[1:0] != 2'b00)));
`else
  assign misalign_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; alu_valid only matters in IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.alu_valid) state_next = (is_mem_c && !misalign_c) ? REQ : DONE;
      REQ:     if (bus.req_ready) state_next = WAIT;
      WAIT:    if (bus.resp_valid) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Store lane placement from the issuing address
  always_comb begin
    st_wdata_c = bus.mem_wdata;
    st_wmask_c = 4'b1111;
    case (bus.mem_len)
      2'b00: begin
        st_wdata_c = {4{bus.mem_wdata[7:0]}};
        st_wmask_c = 4'b0001 << lane_c;
      end
      2'b01: begin
        st_wdata_c = {2{bus.mem_wdata[15:0]}};
        st_wmask_c = 4'b0011 << {lane_c[1], 1'b0};
      end
      default: ;
    endcase
  end

  // Load extraction uses the captured address, since alu_result may have moved on
  assign byte_sh_c = bus.resp_rdata >> {bus.req_addr[1:0], 3'b000};
  assign half_sh_c = bus.resp_rdata >> {bus.req_addr[1], 4'b0000};

  always_comb begin
    load_c = bus.resp_rdata;
    case (len_q)
      2'b00:   load_c = {{24{sign_q & byte_sh_c[7]}}, byte_sh_c[7:0]};
      2'b01:   load_c = {{16{sign_q & half_sh_c[15]}}, half_sh_c[15:0]};
      default: ;
    endcase
  end

  // Registered outputs and captured operation fields
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.req_valid  <= 1'b0;
      bus.req_wen    <= 1'b0;
      bus.req_addr   <= '0;
      bus.req_wdata  <= '0;
      bus.req_wmask  <= '0;
      bus.lsu_valid  <= 1'b0;
      bus.lsu_result <= '0;
      bus.lsu_busy   <= 1'b0;
      bus.lsu_err    <= 1'b0;
      len_q          <= 2'b00;
      sign_q         <= 1'b0;
    end else begin
      bus.req_valid <= (state_next == REQ);
      bus.lsu_valid <= (state_next == DONE);
      bus.lsu_busy  <= (state_next != IDLE);
      bus.lsu_err   <= accept_c && misalign_c;
      if (accept_c) begin
        len_q  <= bus.mem_len;
        sign_q <= bus.mem_sign;
        if (is_mem_c && !misalign_c) begin
          bus.req_addr   <= bus.alu_result;
          bus.req_wen    <= bus.mem_wen;
          bus.req_wdata  <= bus.mem_wen ? st_wdata_c : '0;
          bus.req_wmask  <= bus.mem_wen ? st_wmask_c : '0;
          bus.lsu_result <= '0;
        end else begin
          bus.lsu_result <= bus.alu_result;
        end
      end else if ((state == WAIT) && bus.resp_valid && !bus.req_wen) begin
        bus.lsu_result <= load_c;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_20020207_lsu.sv
// Scoreboard bench for ysyx_20020207_lsu: stimulus queues expected requests/results,
// negedge monitors compare whatever the DUT presents.
module tb_ysyx_20020207_lsu;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ysyx_20020207_lsu_if bus();

  ysyx_20020207_lsu dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  typedef struct packed {
    logic [31:0] result;
    logic        err;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  req_t mon_req;
  rsp_t mon_rsp;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Result monitor
  always @(negedge clock) begin
    if (reset === 1'b0 && bus.lsu_valid === 1'b1) begin
      if (rsp_q.size() == 0) begin
        check("unexpected_lsu_valid", 32'(bus.lsu_valid), 32'd0);
      end else begin
        mon_rsp = rsp_q.pop_front();
        check("lsu_result", bus.lsu_result, mon_rsp.result);
        check("lsu_err", 32'(bus.lsu_err), 32'(mon_rsp.err));
      end
    end
  end

  // Request monitor: every REQ cycle must match the queued request (covers stability)
  always @(negedge clock) begin
    if (reset === 1'b0 && bus.req_valid === 1'b1) begin
      if (req_q.size() == 0) begin
        check("unexpected_req_valid", 32'(bus.req_valid), 32'd0);
      end else begin
        mon_req = req_q[0];
        check("req_addr", bus.req_addr, mon_req.addr);
        check("req_wen", 32'(bus.req_wen), 32'(mon_req.wen));
        check("req_wmask", 32'(bus.req_wmask), 32'(mon_req.wmask));
        if (mon_req.wen) check("req_wdata", bus.req_wdata, mon_req.wdata);
        if (bus.req_ready) void'(req_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic exp_req(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                         input logic [3:0] wmask);
    req_t r;
    r.addr = addr; r.wen = wen; r.wdata = wdata; r.wmask = wmask;
    req_q.push_back(r);
  endtask

  task automatic exp_rsp(input logic [31:0] result, input logic err);
    rsp_t r;
    r.result = result; r.err = err;
    rsp_q.push_back(r);
  endtask

  // One-cycle alu_valid pulse, then scramble the fields to prove they were captured
  task automatic issue(input logic [31:0] res, input logic ren, input logic wen,
                       input logic [1:0] len, input logic sign, input logic [31:0] wdata);
    bus.alu_valid  = 1'b1;
    bus.alu_result = res;
    bus.mem_ren    = ren;
    bus.mem_wen    = wen;
    bus.mem_len    = len;
    bus.mem_sign   = sign;
    bus.mem_wdata  = wdata;
    tick();
    bus.alu_valid  = 1'b0;
    bus.alu_result = 32'hDEAD_BEEF;
    bus.mem_ren    = 1'b0;
    bus.mem_wen    = 1'b0;
    bus.mem_len    = 2'b11;
    bus.mem_sign   = 1'b1;
    bus.mem_wdata  = 32'hFFFF_FFFF;
  endtask

  // Bus responder: stall ready for delay cycles (with stray resp_valid), then respond
  task automatic serve(input int delay, input logic [31:0] rdata, input bit poke);
    int n = 0;
    while (bus.req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.req_valid !== 1'b1) begin
      check("req_timeout", 32'(bus.req_valid), 32'd1);
      return;
    end
    bus.resp_valid = (delay > 0);
    bus.resp_rdata = 32'h0BAD_0BAD;
    repeat (delay) tick();
    bus.resp_valid = 1'b0;
    bus.req_ready  = 1'b1;
    tick();
    bus.req_ready  = 1'b0;
    if (poke) begin
      bus.alu_valid  = 1'b1;
      bus.alu_result = 32'h0000_0999;
      tick();
      bus.alu_valid  = 1'b0;
      check("busy_in_wait", 32'(bus.lsu_busy), 32'd1);
    end
    bus.resp_valid = 1'b1;
    bus.resp_rdata = rdata;
    tick();
    bus.resp_valid = 1'b0;
    bus.resp_rdata = 32'h0;
    check("lsu_valid_after_resp", 32'(bus.lsu_valid), 32'd1);
    tick();
    check("lsu_valid_pulse", 32'(bus.lsu_valid), 32'd0);
    check("idle_after_done", 32'(bus.lsu_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b0;
    bus.alu_valid  = 1'b0;
    bus.alu_result = 32'h0;
    bus.mem_ren    = 1'b0;
    bus.mem_wen    = 1'b0;
    bus.mem_len    = 2'b00;
    bus.mem_sign   = 1'b0;
    bus.mem_wdata  = 32'h0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = 32'h0;
    #1 reset = 1'b1;
    repeat (2) tick();

    check("rst_req_valid", 32'(bus.req_valid), 32'd0);
    check("rst_req_wen", 32'(bus.req_wen), 32'd0);
    check("rst_req_wmask", 32'(bus.req_wmask), 32'd0);
    check("rst_req_addr", bus.req_addr, 32'd0);
    check("rst_req_wdata", bus.req_wdata, 32'd0);
    check("rst_lsu_valid", 32'(bus.lsu_valid), 32'd0);
    check("rst_lsu_busy", 32'(bus.lsu_busy), 32'd0);
    check("rst_lsu_err", 32'(bus.lsu_err), 32'd0);
    check("rst_lsu_result", bus.lsu_result, 32'd0);
    reset = 1'b0;
    tick();

    // Non-memory pass-through, latency 1
    exp_rsp(32'h1234_5678, 1'b0);
    issue(32'h1234_5678, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0);
    check("nonmem_latency", 32'(bus.lsu_valid), 32'd1);
    check("nonmem_busy", 32'(bus.lsu_busy), 32'd1);
    tick();
    check("nonmem_pulse", 32'(bus.lsu_valid), 32'd0);
    check("nonmem_idle", 32'(bus.lsu_busy), 32'd0);

    // Signed / unsigned byte loads from lane 3
    exp_req(32'h8000_0003, 1'b0, 32'h0, 4'b0000);
    exp_rsp(32'hFFFF_FF80, 1'b0);
    issue(32'h8000_0003, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0);
    check("load_req_latency", 32'(bus.req_valid), 32'd1);
    serve(0, 32'h80FF_FFFF, 1'b0);

    exp_req(32'h8000_0003, 1'b0, 32'h0, 4'b0000);
    exp_rsp(32'h0000_0080, 1'b0);
    issue(32'h8000_0003, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
    serve(0, 32'h80FF_FFFF, 1'b0);

    // Half loads: signed upper half, unsigned lower half; word load
    exp_req(32'h0000_0202, 1'b0, 32'h0, 4'b0000);
    exp_rsp(32'hFFFF_8001, 1'b0);
    issue(32'h0000_0202, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0);
    serve(1, 32'h8001_7FFF, 1'b0);

    exp_req(32'h0000_0200, 1'b0, 32'h0, 4'b0000);
    exp_rsp(32'h0000_F00D, 1'b0);
    issue(32'h0000_0200, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0);
    serve(0, 32'h8001_F00D, 1'b0);

    exp_req(32'h0000_0204, 1'b0, 32'h0, 4'b0000);
    exp_rsp(32'hCAFE_F00D, 1'b0);
    issue(32'h0000_0204, 1'b1, 1'b0, 2'b10, 1'b1, 32'h0);
    serve(0, 32'hCAFE_F00D, 1'b0);

    // Half store with ready held low 5 cycles
    exp_req(32'h8000_0002, 1'b1, 32'h1234_1234, 4'b1100);
    exp_rsp(32'h0, 1'b0);
    issue(32'h8000_0002, 1'b0, 1'b1, 2'b01, 1'b0, 32'hABCD_1234);
    serve(5, 32'h0, 1'b0);

    // Byte store lane 1
    exp_req(32'h0000_0101, 1'b1, 32'hA5A5_A5A5, 4'b0010);
    exp_rsp(32'h0, 1'b0);
    issue(32'h0000_0101, 1'b0, 1'b1, 2'b00, 1'b0, 32'h1234_56A5);
    serve(0, 32'h0, 1'b0);

    // ren and wen together act as store; len 11 as word
    exp_req(32'h0000_0300, 1'b1, 32'h1122_3344, 4'b1111);
    exp_rsp(32'h0, 1'b0);
    issue(32'h0000_0300, 1'b1, 1'b1, 2'b11, 1'b0, 32'h1122_3344);
    serve(2, 32'hFFFF_FFFF, 1'b0);

    // alu_valid during WAIT is ignored
    exp_req(32'h0000_0401, 1'b0, 32'h0, 4'b0000);
    exp_rsp(32'h0000_0055, 1'b0);
    issue(32'h0000_0401, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
    serve(0, 32'h0000_5500, 1'b1);

    // Reset in WAIT, late response afterwards
    exp_req(32'h0000_0500, 1'b0, 32'h0, 4'b0000);
    issue(32'h0000_0500, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0);
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    check("wait_busy", 32'(bus.lsu_busy), 32'd1);
    reset = 1'b1;
    #2;
    check("async_rst_busy", 32'(bus.lsu_busy), 32'd0);
    check("async_rst_req_addr", bus.req_addr, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    bus.resp_valid = 1'b1;
    bus.resp_rdata = 32'h0000_0077;
    tick();
    bus.resp_valid = 1'b0;
    check("late_resp_no_valid", 32'(bus.lsu_valid), 32'd0);
    tick();
    check("late_resp_busy", 32'(bus.lsu_busy), 32'd0);
    check("late_resp_result", bus.lsu_result, 32'd0);
    check("late_resp_req_valid", 32'(bus.req_valid), 32'd0);

    // Misaligned word load
`ifdef LSU_MISALIGN_CHECK_EN
    exp_rsp(32'h8000_0001, 1'b1);
    issue(32'h8000_0001, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0);
    check("misalign_latency", 32'(bus.lsu_valid), 32'd1);
    check("misalign_err", 32'(bus.lsu_err), 32'd1);
    tick();
    check("misalign_err_clear", 32'(bus.lsu_err), 32'd0);
`else
    exp_req(32'h8000_0001, 1'b0, 32'h0, 4'b0000);
    exp_rsp(32'h1234_5678, 1'b0);
    issue(32'h8000_0001, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0);
    check("misalign_req_issued", 32'(bus.req_valid), 32'd1);
    serve(0, 32'h1234_5678, 1'b0);
`endif

    repeat (4) tick();
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    check("req_queue_drained", 32'(req_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
